// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in serial-out transmitter.
//
// This block takes a WIDTH-bit word through a valid/ready load port and sends it
// out MSB first. It sends one bit per cycle in which shift_en is high. It is the
// transmit end of a link whose receive end is a SIPO shift register. The SIPO
// shares shift_en, and serial_out drives the SIPO's serial_in.
//
// Optional feature (compile-time macro PISO_TX_HOLD_BUF_EN):
//   This adds a one-word hold register. While a word is shifting, the next word
//   can be accepted and parked in it. It then moves into the shift register on
//   the last-bit edge, so back-to-back words have no IDLE gap.
//
// Parameters:
//   WIDTH       word width in bits (>= 2)
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   shift_en    advance one bit this cycle (ignored while idle)
//   load_valid  load_data holds a word to send
//   load_data   word to send, bit WIDTH-1 first
//   load_ready  word can be accepted this cycle (0 while rst is high)
//   serial_out  current line bit, registered; 0 when idle
//   busy        a word is in the shift register
//   word_done   one-cycle pulse after the final shift edge of a word
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             serial_q, serial_d;
    logic             done_q, done_d;
    logic             accept;
    logic             last_bit;

`ifdef PISO_TX_HOLD_BUF_EN
    logic [WIDTH-1:0] hbuf_q, hbuf_d;
    logic             hbuf_vld_q, hbuf_vld_d;

    // While shifting, a word can be accepted as long as the hold slot is free.
    assign load_ready = !rst && ((state_q == IDLE) || !hbuf_vld_q);
`else
    assign load_ready = !rst && (state_q == IDLE);
`endif

    assign accept   = load_valid && load_ready;
    assign last_bit = (state_q == SHIFT) && shift_en && (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef PISO_TX_HOLD_BUF_EN
        hbuf_d     = hbuf_q;
        hbuf_vld_d = hbuf_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = load_data;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
`ifdef PISO_TX_HOLD_BUF_EN
                // Park an accepted word unless it goes straight into sreg on
                // the last-bit edge below.
                if (accept && !(last_bit && !hbuf_vld_q)) begin
                    hbuf_d     = load_data;
                    hbuf_vld_d = 1'b1;
                end
`endif
                if (shift_en) begin
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    if (last_bit) begin
                        count_d = '0;
                        done_d  = 1'b1;
`ifdef PISO_TX_HOLD_BUF_EN
                        if (hbuf_vld_q) begin
                            sreg_d     = hbuf_q;
                            hbuf_vld_d = 1'b0;
                        end else if (accept) begin
                            sreg_d = load_data;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The line bit is registered, so compute it from next-state values.
        serial_d = (state_d == SHIFT) ? sreg_d[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            count_q  <= '0;
            serial_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_TX_HOLD_BUF_EN
            hbuf_q     <= '0;
            hbuf_vld_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            count_q  <= count_d;
            serial_q <= serial_d;
            done_q   <= done_d;
`ifdef PISO_TX_HOLD_BUF_EN
            hbuf_q     <= hbuf_d;
            hbuf_vld_q <= hbuf_vld_d;
`endif
        end
    end

    assign serial_out = serial_q;
    assign busy       = (state_q == SHIFT);
    assign word_done  = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx -- self-checking bench for piso_tx (WIDTH = 8).
//
// Each cycle the bench drives the inputs and steps a reference model of the
// transmitter. The model tracks the word in flight and how many of its bits
// have been sent. It then compares load_ready, busy, serial_out and word_done
// with the model. A receive shift register built in the bench captures
// serial_out on every enabled edge. When a word completes, it is compared with
// the word that was accepted.
// -----------------------------------------------------------------------------
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_TX_HOLD_BUF_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         shift_en = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_ready, serial_out, busy, word_done;

    piso_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .serial_out(serial_out),
        .busy      (busy),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the word in flight, bits already sent, and the hold slot.
    bit           m_busy = 1'b0;
    int           m_k = 0;
    logic [W-1:0] m_word = '0;
    bit           m_done = 1'b0;
    bit           m_hb_vld = 1'b0;
    logic [W-1:0] m_hb = '0;
    bit           m_acc = 1'b0;
    logic [W-1:0] rx = '0;
    logic [W-1:0] sent_q[$];
    bit           prev_busy = 1'b0;
    int           idle_gaps = 0;

    // One clock cycle: apply inputs, check ready, clock, update the model, check outputs.
    task automatic step(input bit r, input bit se, input bit lv, input logic [W-1:0] ld);
        bit ready_m;
        bit direct;
        logic [W-1:0] exp_word;
        rst = r; shift_en = se; load_valid = lv; load_data = ld;
        #1;
        ready_m = !r && (!m_busy || (HB && !m_hb_vld));
        check("load_ready", load_ready, ready_m);
        m_acc = lv && ready_m;
        if (m_busy && se) rx = {rx[W-2:0], serial_out};
        @(posedge clk);
        #1;
        if (r) begin
            m_busy = 0; m_k = 0; m_done = 0; m_hb_vld = 0;
            sent_q.delete();
        end else begin
            m_done = 0;
            direct = 0;
            if (!m_busy) begin
                if (m_acc) begin
                    m_word = ld; m_k = 0; m_busy = 1;
                    sent_q.push_back(ld);
                end
            end else begin
                if (se) begin
                    m_k++;
                    if (m_k == W) begin
                        m_done = 1; m_k = 0;
                        if (m_hb_vld) begin
                            m_word = m_hb; m_hb_vld = 0;
                        end else if (m_acc) begin
                            m_word = ld; direct = 1;
                            sent_q.push_back(ld);
                        end else begin
                            m_busy = 0;
                        end
                    end
                end
                if (m_acc && !direct) begin
                    m_hb = ld; m_hb_vld = 1;
                    sent_q.push_back(ld);
                end
            end
        end
        check("busy", busy, m_busy);
        check("word_done", word_done, m_done);
        check("serial_out", serial_out, m_busy ? m_word[W-1-m_k] : 1'b0);
        if (m_done) begin
            exp_word = (sent_q.size() > 0) ? sent_q.pop_front() : 'x;
            check("rx_word", rx, exp_word);
        end
        if (prev_busy && !m_busy && !r) idle_gaps++;
        prev_busy = m_busy;
    endtask

    // Offer the words in order, holding each until accepted, shifting continuously.
    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int cycles);
        int n = 0;
        for (int c = 0; c < cycles; c++) begin
            if (n == 0)      step(0, 1, 1, a);
            else if (n == 1) step(0, 1, 1, b);
            else             step(0, 1, 0, '0);
            if (m_acc) n++;
        end
        check("pair_accepted", n, 2);
    endtask

    initial begin
        // Reset with load_valid held: nothing may be accepted.
        step(1, 0, 1, 8'hEE);
        step(1, 1, 1, 8'hEE);
        step(0, 0, 0, '0);

        // Single word, continuous shift.
        step(0, 0, 1, 8'hA5);
        for (int i = 0; i < W + 2; i++) step(0, 1, 0, '0);

        // Gated shift: each bit held two cycles; shift_en in IDLE has no effect.
        step(0, 1, 1, 8'hC3);
        for (int i = 0; i < 2 * W + 2; i++) step(0, (i % 2) == 0, 0, '0);
        step(0, 1, 0, '0);

        // Two words back to back (no gap only with the hold buffer).
        idle_gaps = 0;
        send_pair(8'h3C, 8'h81, 2 * W + 6);
        send_pair(8'hFF, 8'h00, 2 * W + 6);
        check("gap_between_words", idle_gaps, HB ? 2 : 4);

        // Reset three bits into a word, then a clean word.
        step(0, 0, 1, 8'h5A);
        for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        step(0, 1, 0, '0);
        step(0, 0, 1, 8'h0F);
        for (int i = 0; i < W + 1; i++) step(0, 1, 0, '0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 1), W'($urandom));
        end
        for (int i = 0; i < 3 * W; i++) step(0, 1, 0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
